// File: rtl/rng_pkg.sv
// Shared types and LFSR helpers for the random-number arbiter.
// Polynomial x^4+x^3+1; the all-zero state is never allowed.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    RESP
  } rng_state_e;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_NONZERO = 4'b0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    return {r[2:0], r[3] ^ r[2]};
  endfunction

  // Zero would lock the LFSR, so it is replaced on every load path.
  function automatic logic [LFSR_W-1:0] lfsr_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_NONZERO : s;
  endfunction

endpackage

// File: rtl/lfsr4.sv
// 4-bit maximal-length LFSR with load and single-step enable; load beats step.
// State updates one cycle after i_load/i_step; no backpressure.
module lfsr4
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_NONZERO
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_state <= lfsr_fix(SEED);
    end else if (i_load) begin
      o_state <= lfsr_fix(i_seed);
    end else if (i_step) begin
      o_state <= lfsr_next(o_state);
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR; each grant advances it STEPS times.
// o_valid STEPS edges after grant; response held in RESP until i_ready.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter int                STEPS   = 4,
  parameter logic [LFSR_W-1:0] SEED    = 4'b0001
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_ready,
  input  logic                       i_reseed,
  input  logic [LFSR_W-1:0]          i_seed,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic                       o_valid,
  output logic [LFSR_W-1:0]          o_data,
  output logic [$clog2(NUM_REQ)-1:0] o_id,
  output logic                       o_busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PW    = ID_W + 1;
  localparam int CNT_W = $clog2(STEPS) + 1;

  rng_state_e        state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_load;
  logic              lfsr_step;
  logic [ID_W:0]     pick;
  logic              pick_any;
  logic [ID_W-1:0]   pick_id;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PW-1:0]        sum;
    dbl = {req, req} >> p;
    rot = dbl[NUM_REQ-1:0];
    sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sum = PW'(i);
    end
    sum = sum + {1'b0, p};
    if (sum >= PW'(NUM_REQ)) sum = sum - PW'(NUM_REQ);
    return {|req, sum[ID_W-1:0]};
  endfunction

  always_comb begin
    pick     = rr_pick(i_req, ptr);
    pick_any = pick[ID_W];
    pick_id  = pick[ID_W-1:0];
  end

  assign lfsr_load = (state == IDLE) && i_reseed;
  assign lfsr_step = (state == STEP);

  lfsr4 #(
    .SEED (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (lfsr_load),
    .i_seed  (i_seed),
    .i_step  (lfsr_step),
    .o_state (lfsr_q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_id    <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_reseed && pick_any) begin
            o_id   <= pick_id;
            o_gnt  <= NUM_REQ'(1) << pick_id;
            cnt    <= CNT_W'(STEPS - 1);
            o_busy <= 1'b1;
            state  <= STEP;
          end
        end
        STEP: begin
          if (cnt == '0) begin
            // Capture the value the LFSR takes on this same final advance.
            o_data  <= lfsr_next(lfsr_q);
            o_valid <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            ptr     <= (o_id == ID_W'(NUM_REQ - 1)) ? '0 : o_id + ID_W'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboarded random bench for rng_arbiter against a queue-based reference model.
module tb_rng_arbiter;

  localparam int STEPS0 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_r = '0;
  logic       ready_r = 1'b1;
  logic       reseed_r = 1'b0;
  logic [3:0] seed_r = '0;
  logic [3:0] o_gnt;
  logic       o_valid;
  logic [3:0] o_data;
  logic [1:0] o_id;
  logic       o_busy;

  logic [3:0] req1 = '0;
  logic       ready1 = 1'b1;
  logic [3:0] gnt1;
  logic       valid1;
  logic [3:0] data1;
  logic [1:0] id1;
  logic       busy1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [3:0] seen1[$];

  logic [3:0] m_lfsr0 = 4'd1;
  int         m_ptr0 = 0;
  logic [3:0] m_lfsr1 = 4'd1;

  always #5 clk = ~clk;

  rng_arbiter u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req_r), .i_ready(ready_r),
    .i_reseed(reseed_r), .i_seed(seed_r), .o_gnt(o_gnt), .o_valid(o_valid),
    .o_data(o_data), .o_id(o_id), .o_busy(o_busy)
  );

  rng_arbiter #(.NUM_REQ(4), .STEPS(1), .SEED(4'b0001)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_ready(ready1),
    .i_reseed(1'b0), .i_seed(4'h0), .o_gnt(gnt1), .o_valid(valid1),
    .o_data(data1), .o_id(id1), .o_busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: x^4+x^3+1 Fibonacci shift expressed with plain arithmetic.
  function automatic logic [3:0] ref_step(input logic [3:0] x);
    int v;
    v = ((int'(x) << 1) & 15) | (((int'(x) >> 3) ^ (int'(x) >> 2)) & 1);
    return 4'(v);
  endfunction

  task automatic model_draw(input logic [3:0] req, output logic [1:0] id, output logic [3:0] d);
    int k;
    int found;
    found = -1;
    for (int j = 0; j < 4; j++) begin
      k = (m_ptr0 + j) % 4;
      if (found < 0 && req[k]) found = k;
    end
    repeat (STEPS0) m_lfsr0 = ref_step(m_lfsr0);
    id = 2'(found);
    d = m_lfsr0;
    m_ptr0 = (found + 1) % 4;
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid && ready_r) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = q0.pop_front();
        check("u0_data", o_data, e[3:0]);
        check("u0_id", o_id, e[5:4]);
        check("u0_gnt_match", o_gnt, 4'b0001 << e[5:4]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid1 && ready1) begin
      if (q1.size() == 0) begin
        check("u1_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = q1.pop_front();
        check("u1_data", data1, e[3:0]);
        check("u1_id", id1, e[5:4]);
        seen1.push_back(data1);
      end
    end
  end

  task automatic draw(input logic [3:0] req, input bit keep, input int stall, input bit rs_step);
    int n;
    logic [1:0] eid;
    logic [3:0] ed;
    req_r = req;
    ready_r = (stall == 0);
    @(posedge clk);
    model_draw(req, eid, ed);
    q0.push_back({eid, ed});
    #1;
    check("gnt_onehot", o_gnt, 4'b0001 << eid);
    check("busy_on_grant", o_busy, 1'b1);
    if (!keep) req_r = '0;
    if (rs_step) begin
      seed_r = 4'hF;
      reseed_r = 1'b1;
    end
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    reseed_r = 1'b0;
    check("latency", n, STEPS0);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk);
        #1;
        check("hold_valid", o_valid, 1'b1);
        check("hold_data", o_data, ed);
        check("hold_id", o_id, eid);
        check("hold_busy", o_busy, 1'b1);
      end
      ready_r = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_clear", o_valid, 1'b0);
    check("gnt_clear", o_gnt, 4'b0000);
    check("busy_clear", o_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_gnt", o_gnt, 4'b0000);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 4'h0);
    check("rst_id", o_id, 2'd0);
    check("rst_busy", o_busy, 1'b0);

    draw(4'b0001, 0, 0, 0);
    draw(4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) draw(4'b1001, (i < 3), 0, 0);
    draw(4'b0100, 0, 10, 0);
    for (int i = 0; i < 10; i++)
      draw(4'($urandom_range(1, 15)), 0, $urandom_range(0, 3), 0);

    // Reseed with zero beats a simultaneous request.
    req_r = 4'b0010;
    seed_r = 4'h0;
    reseed_r = 1'b1;
    @(posedge clk);
    #1;
    reseed_r = 1'b0;
    m_lfsr0 = 4'd1;
    check("reseed_no_gnt", o_gnt, 4'b0000);
    check("reseed_no_busy", o_busy, 1'b0);
    draw(4'b0010, 0, 0, 0);
    draw(4'b0001, 0, 0, 1);

    // Reset in the middle of a draw.
    req_r = 4'b0001;
    @(posedge clk);
    #1;
    req_r = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("amid_gnt", o_gnt, 4'b0000);
    check("amid_valid", o_valid, 1'b0);
    check("amid_data", o_data, 4'h0);
    check("amid_id", o_id, 2'd0);
    check("amid_busy", o_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_lfsr0 = 4'd1;
    m_ptr0 = 0;
    m_lfsr1 = 4'd1;
    draw(4'b0001, 0, 0, 0);
    check("u0_queue_drained", q0.size(), 0);

    // STEPS=1 instance: full period then wrap.
    for (int i = 0; i < 16; i++) begin
      m_lfsr1 = ref_step(m_lfsr1);
      q1.push_back({2'd0, m_lfsr1});
    end
    req1 = 4'b0001;
    ready1 = 1'b1;
    n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req1 = '0;
    repeat (5) @(posedge clk);
    check("u1_queue_drained", q1.size(), 0);
    check("u1_seen_count", seen1.size(), 16);
    if (seen1.size() == 16) begin
      for (int v = 1; v < 16; v++) begin
        cnt = 0;
        for (int j = 0; j < 15; j++) if (seen1[j] == 4'(v)) cnt++;
        check("u1_period_unique", cnt, 1);
      end
      check("u1_wrap", seen1[15], seen1[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one 4-bit maximal-length LFSR among `NUM_REQ` requesters (dice, player slots, display effects) in the lab1 random-number design. Each granted draw advances the LFSR a fixed `STEPS` times, then returns the value through a valid/ready handshake tagged with the requester id. Arbitration is round-robin, and the LFSR advances only on draws, so sequences are deterministic for a given seed.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `STEPS`, default 4: LFSR advances per draw, at least 1.
- `SEED`, default 4'b0001: LFSR reset value. 4'b0000 is replaced by 4'b0001.

Ports:
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  NUM_REQ: level request per requester.
- `i_ready`  in  1: consumer accepts the response.
- `i_reseed`  in  1: load `i_seed` into the LFSR; honoured only in IDLE.
- `i_seed`  in  4: new seed. 0 is loaded as 4'b0001.
- `o_gnt`  out  NUM_REQ: one-hot grant, high from grant until response accepted.
- `o_valid`  out  1: response valid.
- `o_data`  out  4: drawn value.
- `o_id`  out  $clog2(NUM_REQ): index of granted requester.
- `o_busy`  out  1: high whenever state ≠ IDLE.

## Operation
- LFSR polynomial is x^4+x^3+1. Each step computes next = {r[2:0], r[3]^r[2]}. Period is 15 and the state is never 0.
- States are IDLE, STEP and RESP.
- **IDLE**
  - If `i_reseed`: load the LFSR and do not arbitrate this cycle. Reseed wins over a simultaneous request.
  - Otherwise, if any `i_req` bit is set, grant the first set bit searching upward from `ptr`, wrapping at `NUM_REQ`.
  - On grant: latch id, set `o_gnt`, load `cnt`=STEPS-1, go to STEP.
- **STEP**
  - Advance the LFSR once per cycle.
  - When `cnt`==0 (on that same advance), go to RESP. Otherwise decrement `cnt`.
- **RESP**
  - `o_valid`=1. `o_data` equals the LFSR state and is held stable, as is `o_id`.
  - On `o_valid`&&`i_ready`: clear `o_valid` and `o_gnt`, set `ptr`=(id+1) mod NUM_REQ, return to IDLE.
- Requests are sampled only in IDLE. A request that drops after grant still completes its draw.
- `i_reseed` outside IDLE is ignored; it is not queued.
- `ptr` width is $clog2(NUM_REQ). `cnt` width is $clog2(STEPS)+1. All arithmetic is unsigned with explicit wrap.

## Timing
- **Reset values:** state IDLE, LFSR=SEED (nonzero-corrected), `ptr`=0, `cnt`=0, `o_gnt`=0, `o_valid`=0, `o_data`=0, `o_id`=0, `o_busy`=0.
- **Reset mid-draw:** the draw is aborted immediately. No response is delivered and the LFSR returns to SEED.
- **Latency:** request sampled at edge E0 gives `o_gnt` and `o_busy` after E0, and `o_valid` after edge E0+STEPS.
- `o_data` changes only on entry to RESP.
- **Back-to-back draws:** the handshake at edge H returns to IDLE; the next grant is possible at edge H+1. Minimum spacing between grants is STEPS+2 cycles when `i_ready` is held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `rng_pkg` holds:
  - `rng_state_e` (IDLE/STEP/RESP);
  - `LFSR_W`=4;
  - function `lfsr_next(logic [3:0])`;
  - constant `LFSR_NONZERO`=4'b0001.
- Sub-module `lfsr4`:
  - inputs: `i_clk`, `i_rst`, `i_load`, `i_seed`, `i_step`;
  - output: `o_state`.
- Round-robin pick lives in the top as a combinational rotate-and-priority function.

## Test plan
- Reset with NUM_REQ=4, STEPS=4, SEED=1. Pulse `i_req`=4'b0001 with `i_ready`=1 → `o_valid` after 4 edges, `o_data`=4'h3, `o_id`=0. A second draw → `o_data`=4'h5.
- `i_req`=4'b1001 held → grants in order 0, 3, 0, 3, with `o_gnt` one-hot and matching `o_id` each time.
- `i_ready`=0 for 10 cycles in RESP → `o_valid`, `o_data` and `o_id` stay constant; no LFSR advance; `o_busy`=1.
- `i_reseed`=1, `i_seed`=0 in IDLE with `i_req`=4'b0010 → LFSR=4'b0001, no grant that cycle, grant to 1 next cycle, `o_data`=4'h3. A reseed during STEP has no effect.
- `i_rst` asserted mid-STEP → all outputs 0 asynchronously, state IDLE, next draw from req0 returns 4'h3.
- 15 consecutive draws with STEPS=1 → all 15 nonzero values appear exactly once, then the sequence repeats.
